// File: rtl/sound_request_arbiter.sv
// Fixed-priority arbiter that plays one ROM sound at a time into the codec, advancing once per LR frame.
// Grant one edge after arbitration; preemption aborts via START; a silent gap separates sounds.
module sound_request_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int IDX_W        = 2,
    parameter int ADDR_W       = 10,
    parameter int SOUND_FRAMES = 1024,
    parameter int GAP_FRAMES   = 16,
    parameter int PREEMPT      = 1
) (
    input  logic               xck_clock,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               frame_tick,
    output logic [NUM_REQ-1:0] ack,
    output logic [NUM_REQ-1:0] done,
    output logic               aborted,
    output logic               busy,
    output logic               sound_enable,
    output logic [IDX_W-1:0]   grant_idx,
    output logic [ADDR_W-1:0]  sample_addr
);

    localparam int GAP_W = (GAP_FRAMES > 1) ? $clog2(GAP_FRAMES) : 1;
    localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'((GAP_FRAMES > 0) ? GAP_FRAMES - 1 : 0);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SOUND_FRAMES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_PLAY  = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    grant_q, grant_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [NUM_REQ-1:0]  ack_q, ack_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic                aborted_q, aborted_d;
    logic                busy_q, busy_d;
    logic                en_q, en_d;

    logic                any_req;
    logic [IDX_W-1:0]    win_idx;
    logic                preempt_hit;

    // Lowest set index wins; preemption needs a strictly higher-priority request.
    always_comb begin
        any_req     = |req;
        win_idx     = '0;
        preempt_hit = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_idx = IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req[i] && (IDX_W'(i) < grant_q)) begin
                preempt_hit = 1'b1;
            end
        end
        if (PREEMPT == 0) begin
            preempt_hit = 1'b0;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        addr_d    = addr_q;
        gap_d     = gap_q;
        ack_d     = '0;
        done_d    = '0;
        aborted_d = 1'b0;
        case (state_q)
            S_IDLE, S_START: begin
                if (any_req) begin
                    grant_d = win_idx;
                    addr_d  = '0;
                    ack_d   = NUM_REQ'(1) << win_idx;
                    state_d = S_PLAY;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PLAY: begin
                if (preempt_hit) begin
                    done_d    = NUM_REQ'(1) << grant_q;
                    aborted_d = 1'b1;
                    state_d   = S_START;
                end else if (frame_tick) begin
                    if (addr_q == LAST_ADDR) begin
                        done_d  = NUM_REQ'(1) << grant_q;
                        gap_d   = GAP_LOAD;
                        state_d = (GAP_FRAMES == 0) ? S_IDLE : S_GAP;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (frame_tick) begin
                    if (gap_q == '0) begin
                        state_d = S_IDLE;
                    end else begin
                        gap_d = gap_q - 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Status outputs follow the next state so they are registered alongside it.
        busy_d = (state_d != S_IDLE);
        en_d   = (state_d == S_PLAY);
    end

    always_ff @(posedge xck_clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            grant_q   <= '0;
            addr_q    <= '0;
            gap_q     <= '0;
            ack_q     <= '0;
            done_q    <= '0;
            aborted_q <= 1'b0;
            busy_q    <= 1'b0;
            en_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            addr_q    <= addr_d;
            gap_q     <= gap_d;
            ack_q     <= ack_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            busy_q    <= busy_d;
            en_q      <= en_d;
        end
    end

    assign ack          = ack_q;
    assign done         = done_q;
    assign aborted      = aborted_q;
    assign busy         = busy_q;
    assign sound_enable = en_q;
    assign grant_idx    = grant_q;
    assign sample_addr  = addr_q;

endmodule

// File: tb/tb_sound_request_arbiter.sv
// Directed bench: default arbiter (preempting, 1024-frame sounds, 16-frame gap) plus a
// non-preempting, gapless 4-frame instance sharing clock, reset and frame_tick.
module tb_sound_request_arbiter;

    logic       xck_clock;
    logic       rst_n;
    logic       frame_tick;
    logic [3:0] req;
    logic [3:0] ack, done;
    logic       aborted, busy, sound_enable;
    logic [1:0] grant_idx;
    logic [9:0] sample_addr;

    logic [3:0] req1;
    logic [3:0] ack1, done1;
    logic       aborted1, busy1, sound_enable1;
    logic [1:0] grant_idx1;
    logic [9:0] sample_addr1;

    int checks = 0;
    int errors = 0;

    sound_request_arbiter u_dut (
        .xck_clock(xck_clock), .rst_n(rst_n), .req(req), .frame_tick(frame_tick),
        .ack(ack), .done(done), .aborted(aborted), .busy(busy),
        .sound_enable(sound_enable), .grant_idx(grant_idx), .sample_addr(sample_addr)
    );

    sound_request_arbiter #(
        .SOUND_FRAMES(4), .GAP_FRAMES(0), .PREEMPT(0)
    ) u_nopre (
        .xck_clock(xck_clock), .rst_n(rst_n), .req(req1), .frame_tick(frame_tick),
        .ack(ack1), .done(done1), .aborted(aborted1), .busy(busy1),
        .sound_enable(sound_enable1), .grant_idx(grant_idx1), .sample_addr(sample_addr1)
    );

    initial xck_clock = 1'b0;
    always #5 xck_clock = ~xck_clock;

    task automatic cyc();
        @(posedge xck_clock);
        #1;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    initial begin
        rst_n      = 1'b0;
        req        = 4'b0;
        req1       = 4'b0;
        frame_tick = 1'b0;
        #3;
        chk("rst_ack",   ack,          0);
        chk("rst_done",  done,         0);
        chk("rst_abort", aborted,      0);
        chk("rst_busy",  busy,         0);
        chk("rst_en",    sound_enable, 0);
        chk("rst_grant", grant_idx,    0);
        chk("rst_addr",  sample_addr,  0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // 1: single request, full sound, gap, back to idle
        req = 4'b0100;
        cyc();
        req = 4'b0;
        chk("t1_ack",   ack,          4'b0100);
        chk("t1_grant", grant_idx,    2);
        chk("t1_en",    sound_enable, 1);
        chk("t1_addr0", sample_addr,  0);
        cyc();
        chk("t1_ack_pulse", ack, 0);
        tick();
        chk("t1_addr1", sample_addr, 1);
        ticks(1022);
        chk("t1_addr_last", sample_addr, 1023);
        chk("t1_no_done",   done,        0);
        tick();
        chk("t1_done",     done,         4'b0100);
        chk("t1_abort",    aborted,      0);
        chk("t1_en_gap",   sound_enable, 0);
        chk("t1_busy_gap", busy,         1);
        cyc();
        chk("t1_done_pulse", done, 0);
        ticks(15);
        chk("t1_gap_busy", busy, 1);
        tick();
        chk("t1_idle", busy, 0);

        // non-preempting, gapless instance: req[0] never preempts idx 1
        req1 = 4'b0010;
        cyc();
        chk("np_ack",   ack1,       4'b0010);
        chk("np_grant", grant_idx1, 1);
        req1 = 4'b0001;
        cyc();
        chk("np_no_pre", done1, 0);
        chk("np_busy",   busy1, 1);
        ticks(3);
        chk("np_addr3", sample_addr1, 3);
        tick();
        chk("np_done",  done1,    4'b0010);
        chk("np_abort", aborted1, 0);
        chk("np_idle",  busy1,    0);
        cyc();
        chk("np_reack", ack1,       4'b0001);
        chk("np_regnt", grant_idx1, 0);
        req1 = 4'b0;
        chk("idle_tick_ignored", busy, 0);

        // 2: simultaneous requests; lower-priority req[3] does not preempt
        req = 4'b1010;
        cyc();
        chk("t2_ack",   ack,       4'b0010);
        chk("t2_grant", grant_idx, 1);
        req = 4'b1000;
        ticks(10);
        chk("t2_no_pre", done,        0);
        chk("t2_addr10", sample_addr, 10);
        ticks(1013);
        chk("t2_addr_last", sample_addr, 1023);
        tick();
        chk("t2_done",  done,    4'b0010);
        chk("t2_abort", aborted, 0);
        ticks(15);
        chk("t2_gap_no_ack", ack, 0);
        tick();
        chk("t2_idle", busy, 0);
        cyc();
        chk("t2_ack3",   ack,       4'b1000);
        chk("t2_grant3", grant_idx, 3);
        req = 4'b0;

        // 6: asynchronous reset mid-play
        ticks(500);
        chk("t6_addr500", sample_addr, 500);
        rst_n = 1'b0;
        #1;
        chk("t6_addr", sample_addr,  0);
        chk("t6_busy", busy,         0);
        chk("t6_en",   sound_enable, 0);
        chk("t6_grnt", grant_idx,    0);
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("t6_no_done", done, 0);
        cyc();
        chk("t6_idle",  busy, 0);
        chk("t6_done2", done, 0);

        // 3: preemption at address 37
        req = 4'b0100;
        cyc();
        chk("t3_ack", ack, 4'b0100);
        req = 4'b0;
        ticks(37);
        chk("t3_addr37", sample_addr, 37);
        req = 4'b0001;
        cyc();
        chk("t3_done",  done,         4'b0100);
        chk("t3_abort", aborted,      1);
        chk("t3_en",    sound_enable, 0);
        chk("t3_busy",  busy,         1);
        cyc();
        req = 4'b0;
        chk("t3_ack0",  ack,          4'b0001);
        chk("t3_grant", grant_idx,    0);
        chk("t3_addr0", sample_addr,  0);
        chk("t3_en2",   sound_enable, 1);
        chk("t3_abort_pulse", aborted, 0);
        do_reset();

        // 5: preemption coinciding with the final-frame tick
        req = 4'b0100;
        cyc();
        req = 4'b0;
        ticks(1023);
        chk("t5_addr_last", sample_addr, 1023);
        req        = 4'b0001;
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        chk("t5_done",  done,        4'b0100);
        chk("t5_abort", aborted,     1);
        chk("t5_addr",  sample_addr, 1023);
        cyc();
        req = 4'b0;
        chk("t5_ack0", ack,         4'b0001);
        chk("t5_addr0", sample_addr, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
